// File: rtl/ddr_diff_pattern_gen.sv
// Multi-lane, tick-paced DDR pattern source for ODDR D0/D1 and ELVDS_TBUF OEN.
// An enable FSM keeps the buffers tristated through warm-up and drains the last symbol.
module ddr_diff_pattern_gen #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DIV_WIDTH = 25,
    parameter int unsigned WARMUP    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick,
    output logic [CHANNELS-1:0]  d0,
    output logic [CHANNELS-1:0]  d1,
    output logic [CHANNELS-1:0]  oen_n,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        PAT_TOGGLE,
        PAT_SLOW,
        PAT_PRBS,
        PAT_WALK
    } pat_t;

    localparam logic [6:0] LFSR_SEED = 7'h7F;
    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    pat_t                  r_mode;
    logic [DIV_WIDTH-1:0]  r_presc;
    logic [7:0]            r_wcnt;
    logic [6:0]            r_lfsr;
    logic                  r_phase;
    logic [CHANNELS-1:0]   r_walk;
    logic [CHANNELS-1:0]   r_d0;
    logic [CHANNELS-1:0]   r_d1;
    logic [CHANNELS-1:0]   r_oen_n;

    logic                  w_busy;
    logic                  w_tick;
    logic                  w_start;
    logic                  w_step;
    logic                  w_stop;
    logic                  w_b1;
    logic                  w_b2;
    logic [6:0]            w_lfsr_nxt;
    logic [CHANNELS-1:0]   w_walk_rot;
    logic [CHANNELS-1:0]   w_d0_nxt;
    logic [CHANNELS-1:0]   w_d1_nxt;

    assign w_busy = (r_state != ST_IDLE);
    assign w_tick = w_busy && (r_presc == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_WARMUP;
                    w_start     = 1'b1;
                end
            end
            ST_WARMUP: begin
                if (w_tick) begin
                    if (!enable) begin
                        w_state_nxt = ST_IDLE;
                        w_stop      = 1'b1;
                    end else begin
                        w_step = 1'b1;
                        if (r_wcnt == WARM_LAST) begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                w_step = w_tick;
                if (!enable) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_stop      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Two LFSR steps per tick: second bit uses the once-shifted register, i.e. s[5]^s[4].
    assign w_b1       = r_lfsr[6] ^ r_lfsr[5];
    assign w_b2       = r_lfsr[5] ^ r_lfsr[4];
    assign w_lfsr_nxt = {r_lfsr[4:0], w_b1, w_b2};

    always_comb begin
        w_walk_rot = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_walk_rot[(k + 1) % CHANNELS] = r_walk[k];
        end
    end

    always_comb begin
        w_d0_nxt = '0;
        w_d1_nxt = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            case (r_mode)
                PAT_TOGGLE: begin
                    w_d0_nxt[k] = k[0];
                    w_d1_nxt[k] = ~k[0];
                end
                PAT_SLOW: begin
                    w_d0_nxt[k] = r_phase ^ k[0];
                    w_d1_nxt[k] = r_phase ^ k[0];
                end
                PAT_PRBS: begin
                    w_d0_nxt[k] = w_b1 ^ k[0];
                    w_d1_nxt[k] = w_b2 ^ k[0];
                end
                default: begin
                    w_d0_nxt[k] = r_walk[k];
                    w_d1_nxt[k] = r_walk[k];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!w_busy || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= PAT_TOGGLE;
            r_wcnt  <= '0;
            r_lfsr  <= LFSR_SEED;
            r_phase <= 1'b0;
            r_walk  <= CHANNELS'(1);
            r_d0    <= '0;
            r_d1    <= '0;
            r_oen_n <= '1;
        end else begin
            if (w_start) begin
                r_mode  <= pat_t'(mode);
                r_wcnt  <= '0;
                r_lfsr  <= LFSR_SEED;
                r_phase <= 1'b0;
                r_walk  <= CHANNELS'(1);
            end
            if (w_step) begin
                r_wcnt  <= r_wcnt + 1'b1;
                r_lfsr  <= w_lfsr_nxt;
                r_phase <= ~r_phase;
                r_walk  <= w_walk_rot;
                r_d0    <= w_d0_nxt;
                r_d1    <= w_d1_nxt;
            end
            if (w_stop) begin
                r_d0 <= '0;
                r_d1 <= '0;
            end
            r_oen_n <= (w_state_nxt == ST_RUN || w_state_nxt == ST_DRAIN) ? '0 : '1;
        end
    end

    assign tick  = w_tick;
    assign busy  = w_busy;
    assign d0    = r_d0;
    assign d1    = r_d1;
    assign oen_n = r_oen_n;

endmodule

// File: tb/tb_ddr_diff_pattern_gen.sv
// Self-checking bench for ddr_diff_pattern_gen: tick-count reference model of runs,
// warm-up, drain and per-lane patterns, plus asynchronous reset checks.
module tb_ddr_diff_pattern_gen;

    localparam int CH  = 4;
    localparam int DW  = 8;
    localparam int WU  = 4;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic          tick;
    logic [CH-1:0] d0;
    logic [CH-1:0] d1;
    logic [CH-1:0] oen_n;
    logic          busy;

    int errors = 0;
    int checks = 0;
    bit prbs [0:511];

    ddr_diff_pattern_gen #(
        .CHANNELS  (CH),
        .DIV_WIDTH (DW),
        .WARMUP    (WU)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .mode   (mode),
        .div    (div),
        .tick   (tick),
        .d0     (d0),
        .d1     (d1),
        .oen_n  (oen_n),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected lane vector after t pattern steps; second selects the D1 half of the symbol.
    function automatic logic [CH-1:0] exp_d(input int m, input int t, input bit second);
        logic [CH-1:0] r;
        r = '0;
        if (t == 0) return r;
        for (int k = 0; k < CH; k++) begin
            bit odd;
            odd = (k % 2) == 1;
            case (m)
                0: r[k] = second ? !odd : odd;
                1: r[k] = ((t - 1) % 2 == 1) ^ odd;
                2: r[k] = prbs[2 * t - 2 + int'(second)] ^ odd;
                default: r[k] = ((t - 1) % CH) == k;
            endcase
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One enable episode: enable held for en_cyc busy cycles, optional re-request during drain.
    task automatic run_seq(input int m, input int dv, input int en_cyc, input bit reen);
        int  c;
        int  t;
        bit  drain;
        bit  ended;
        bit  etick;
        mode   = 2'(m);
        div    = DW'(dv);
        enable = 1'b1;
        cyc();
        c = 1; t = 0; drain = 0; ended = 0;
        while (!ended && c < 4000) begin
            etick = (c % (dv + 1)) == 0;
            chk($sformatf("busy m%0d c%0d", m, c), 32'(busy), 32'd1);
            chk($sformatf("tick m%0d c%0d", m, c), 32'(tick), 32'(etick));
            chk($sformatf("oen m%0d c%0d", m, c), 32'(oen_n), (t >= WU) ? 32'h0 : 32'hF);
            chk($sformatf("d0 m%0d c%0d", m, c), 32'(d0), 32'(exp_d(m, t, 1'b0)));
            chk($sformatf("d1 m%0d c%0d", m, c), 32'(d1), 32'(exp_d(m, t, 1'b1)));
            mode = 2'($urandom_range(0, 3));
            if (c >= en_cyc) enable = 1'b0;
            if (reen && drain) enable = 1'b1;
            if (t < WU) begin
                if (etick) begin
                    if (!enable) ended = 1;
                    else t++;
                end
            end else if (drain) begin
                if (etick) ended = 1;
            end else begin
                if (!enable) drain = 1;
                if (etick) t++;
            end
            cyc();
            c++;
        end
        chk("run_timeout", 32'(ended), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_oen", 32'(oen_n), 32'hF);
        chk("end_d0", 32'(d0), 32'h0);
        chk("end_d1", 32'(d1), 32'h0);
        chk("end_tick", 32'(tick), 32'd0);
        if (reen && drain) begin
            cyc();
            chk("restart_busy", 32'(busy), 32'd1);
            enable = 1'b0;
            for (int i = 0; i < dv + 3 && busy; i++) cyc();
            chk("restart_abort", 32'(busy), 32'd0);
        end
        enable = 1'b0;
    endtask

    initial begin
        int seq [0:518];
        for (int i = 0; i < 7; i++) seq[i] = 1;
        for (int n = 7; n < 519; n++) seq[n] = seq[n - 7] ^ seq[n - 6];
        for (int i = 0; i < 512; i++) prbs[i] = seq[i + 7] == 1;

        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'd0;
        div    = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_oen", 32'(oen_n), 32'hF);
        chk("rst_d0", 32'(d0), 32'h0);
        chk("rst_d1", 32'(d1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        run_seq(0, 3, 40, 0);
        run_seq(2, 0, 140, 0);
        run_seq(3, 1, 30, 0);
        run_seq(1, 9, 8, 0);
        run_seq(1, 9, 60, 0);
        run_seq(1, 2, 30, 1);
        run_seq(2, 1, 30, 0);
        repeat (6) begin
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    int'($urandom_range(1, 80)), bit'($urandom_range(0, 1)));
        end

        mode   = 2'd0;
        div    = DW'(2);
        enable = 1'b1;
        for (int i = 0; i < 100 && oen_n != '0; i++) cyc();
        chk("rst_prep_oen", 32'(oen_n), 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_oen", 32'(oen_n), 32'hF);
        chk("arst_d0", 32'(d0), 32'h0);
        chk("arst_d1", 32'(d1), 32'h0);
        chk("arst_tick", 32'(tick), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
